// File: rtl/pw_frame_sched.sv
// pw_frame_sched
//
// Round-robin scheduler that lets NREQ pulse-width serial receivers share one
// 3-bit LED register. The scheduler grants one receiver at a time and captures
// its 8-bit frame: bits [7:3] hold the address and bits [2:0] hold the LED payload.
// If the address equals i_ref, the payload is written to the LED register.
// After each LED write, the scheduler waits HOLD_CYC idle cycles before it
// grants again.
//
// Ports
//   i_clock      system clock, all state changes on the rising edge
//   i_reset      synchronous active-high reset
//   i_req_valid  per-channel frame-present flags (held until the ready pulse)
//   i_req_data   channel i frame in bits [8i+7:8i]
//   o_req_ready  one-hot single-cycle acceptance pulse to the granted channel
//   i_ref        address compared against frame bits [7:3]
//   o_led        shared LED register
//   o_grant_id   index of the last granted channel
//   o_busy       high whenever the scheduler is not idle
//   o_drop_cnt   saturating count of address mismatches
//
// Optional feature: define PWSCHED_DROP_CNT_EN to build the 8-bit saturating
// mismatch counter. If the macro is not defined, o_drop_cnt is tied to zero.

module pw_frame_sched #(
  parameter int NREQ     = 4,
  parameter int GW       = 2,
  parameter int HOLD_CYC = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [8*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [4:0]        i_ref,
  output logic [2:0]        o_led,
  output logic [GW-1:0]     o_grant_id,
  output logic              o_busy,
  output logic [7:0]        o_drop_cnt
);

  localparam int            HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [GW-1:0] LAST_CH   = GW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, CHECK, HOLD} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [GW-1:0]   r_grantId;
  logic [GW-1:0]   r_ptr;
  logic [HW-1:0]   r_holdCnt;
  logic [7:0]      r_frame;
  logic [2:0]      r_led;

  logic [GW-1:0]   w_sel;
  logic [GW-1:0]   w_selHi;
  logic [GW-1:0]   w_selLo;
  logic            w_foundHi;
  logic            w_anyValid;
  logic            w_grantValid;
  logic [7:0]      w_grantData;
  logic            w_match;

  // Round-robin search without a modulo rotation. The lowest valid channel
  // at or above the pointer wins. If no such channel exists, the search wraps
  // and the lowest valid channel overall wins. A descending scan means the
  // last hit is the lowest index.
  always_comb begin
    w_selHi    = '0;
    w_selLo    = '0;
    w_foundHi  = 1'b0;
    w_anyValid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        w_selLo    = GW'(i);
        w_anyValid = 1'b1;
        if (GW'(i) >= r_ptr) begin
          w_selHi   = GW'(i);
          w_foundHi = 1'b1;
        end
      end
    end
    w_sel = w_foundHi ? w_selHi : w_selLo;
  end

  assign w_grantValid = i_req_valid[r_grantId];
  assign w_grantData  = i_req_data[{r_grantId, 3'b000} +: 8];
  assign w_match      = (r_frame[7:3] == i_ref);

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic. If the requester withdraws during ACCEPT, the
  // scheduler returns to IDLE without capturing a frame.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyValid) w_nextState = ACCEPT;
      ACCEPT:  w_nextState = w_grantValid ? CHECK : IDLE;
      CHECK:   w_nextState = (w_match && (HOLD_CYC > 0)) ? HOLD : IDLE;
      HOLD:    if (r_holdCnt == '0) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath registers. The pointer advances only after a frame is
  // captured, so a withdrawn grant does not cost that channel its turn.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_grantId <= '0;
      r_ptr     <= '0;
      r_holdCnt <= '0;
      r_frame   <= '0;
      r_led     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_anyValid) r_grantId <= w_sel;
        ACCEPT: begin
          if (w_grantValid) begin
            r_frame <= w_grantData;
            r_ptr   <= (r_grantId == LAST_CH) ? '0 : r_grantId + GW'(1);
          end
        end
        CHECK: begin
          if (w_match) begin
            r_led     <= r_frame[2:0];
            r_holdCnt <= HOLD_LOAD;
          end
        end
        HOLD: if (r_holdCnt != '0) r_holdCnt <= r_holdCnt - HW'(1);
        default: ;
      endcase
    end
  end

`ifdef PWSCHED_DROP_CNT_EN
  logic [7:0] r_dropCnt;

  // Count rejected frames. The counter sticks at 255 and clears only on reset.
  always_ff @(posedge i_clock) begin
    if (i_reset)                                                  r_dropCnt <= 8'h00;
    else if (r_state == CHECK && !w_match && r_dropCnt != 8'hFF)  r_dropCnt <= r_dropCnt + 8'd1;
  end

  assign o_drop_cnt = r_dropCnt;
`else
  assign o_drop_cnt = 8'h00;
`endif

  // Output decode. Ready and busy are forced low while reset is held, so
  // a requester never sees an acceptance during reset.
  always_comb begin
    o_req_ready = '0;
    o_busy      = 1'b0;
    if (!i_reset) begin
      o_busy = (r_state != IDLE);
      if (r_state == ACCEPT) o_req_ready[r_grantId] = 1'b1;
    end
  end

  assign o_led      = r_led;
  assign o_grant_id = r_grantId;

endmodule

// File: doc/pw_frame_sched.md
Name: pw_frame_sched

Overview:
- Round-robin scheduler that shares one LED output register between NREQ pulse-width serial receivers.
- Each receiver delivers a decoded 8-bit frame: bits [7:3] are the address, bits [2:0] are the LED payload.
- The block grants one receiver at a time and captures its frame.
- If the frame address equals ref, it updates led, then holds off further grants for a programmable window.

Parameters:
- NREQ, 4, number of requester channels (2..8).
- GW, 2, grant index width; must satisfy 2**GW >= NREQ.
- HOLD_CYC, 16, idle cycles after a successful LED update before the next grant; 0 disables the hold.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i = channel i presents a frame; held until its req_ready pulse.
- req_data  input  8*NREQ  frame of channel i in bits [8i+7:8i].
- req_ready  output  NREQ  one-hot; single-cycle acceptance pulse to the granted channel.
- ref  input  5  address to match against frame bits [7:3].
- led  output  3  shared LED register.
- grant_id  output  GW  index of the last granted channel.
- busy  output  1  high whenever state != IDLE.
- drop_cnt  output  8  mismatch counter (see Optional Feature).

Behaviour:
- Reset (synchronous, while reset=1 at posedge):
  - state=IDLE; led=0; grant_id=0; rr pointer=0; hold counter=0; frame register=0; drop_cnt=0.
  - req_ready=0 and busy=0 while in reset.
  - Reset mid-operation aborts any grant in progress; no LED write occurs.
- States: IDLE, ACCEPT, CHECK, HOLD.
- IDLE:
  - If any req_valid bit is set, select the first set channel searching ptr, ptr+1, ... mod NREQ.
  - grant_id <= selected channel; go to ACCEPT.
  - Otherwise stay in IDLE.
- ACCEPT:
  - req_ready[grant_id]=1 for exactly this cycle; all other ready bits are 0.
  - ready is decoded combinationally from state and grant_id.
  - At the posedge: if req_valid[grant_id]=1, frame <= that channel's data, ptr <= (grant_id+1) mod NREQ, go to CHECK.
  - If req_valid[grant_id]=0 (requester withdrew), capture nothing, leave ptr unchanged, go to IDLE.
- CHECK:
  - ref is sampled in this cycle.
  - Match (frame[7:3]==ref): led <= frame[2:0]. If HOLD_CYC>0, go to HOLD with counter = HOLD_CYC-1; if HOLD_CYC=0, go to IDLE.
  - Mismatch: led unchanged; go to IDLE.
- HOLD:
  - Counter decrements each cycle; go to IDLE on the cycle the counter reaches 0.
  - Total HOLD residency is HOLD_CYC cycles.
  - Requests arriving during HOLD wait; none are lost while valid is held.
- Latency:
  - Valid sampled in IDLE at edge k → ready high during cycle k..k+1 → led updated at edge k+2.
  - Minimum grant-to-grant spacing: 3 cycles plus HOLD_CYC on a match.
- Fairness:
  - A channel granted at edge k cannot be granted again before every other continuously valid channel has been granted once.
  - Pointer wrap: when grant_id=NREQ-1 the next search starts at 0.
- Channels with index >= NREQ do not exist; grant_id never exceeds NREQ-1.
- Matching frames with the same payload still count as LED writes and still trigger HOLD.

Optional Feature:
- Macro: PWSCHED_DROP_CNT_EN.
- Defined: drop_cnt increments by 1 at each CHECK mismatch and saturates at 255; it is cleared only by reset.
- Undefined: drop_cnt is tied to 8'h00, no counter register exists, and all other behaviour is identical.

Test Plan:
- Reset then idle: ref=5'h0A, no valid for 20 cycles → led=0, req_ready=0, busy=0, grant_id=0.
- Single match: ch1 valid with data 8'h55 (addr 5'h0A, payload 3'b101), ref=5'h0A → req_ready=4'b0010 for one cycle, led=3'b101 two edges after valid is sampled, busy high for 2+16 cycles.
- Round-robin: ch0 and ch2 continuously valid, all frames mismatching → grant order 0,2,0,2; ready pulses spaced 3 cycles apart; led stays 0; drop_cnt=4 after four grants (macro defined).
- Hold window: ch3 matches, then ch0 asserts valid 1 cycle later → ch0 ready appears only after 16 HOLD cycles plus IDLE; ch0's frame is then processed normally.
- Withdrawal and reset: ch2 drops valid during ACCEPT → no capture, ptr unchanged, return to IDLE. Separately, assert reset during CHECK of a matching frame → led=0 and state=IDLE on the next cycle.
- Saturation: 300 mismatching frames with macro defined → drop_cnt=255. With macro undefined → drop_cnt=0.
